instr_queue: RTL
================

# instr_queue

Instruction queue between the fetch unit and dispatch. Buffers up to `IQ_DEPTH` fetched instructions with their PC and predicted nPC, and raises a stall back to fetch when full. Flushes completely on a pipeline-resolved redirect. Decouples I$ hit timing from dispatch back-pressure.

## Interface

Parameters:
- `IQ_DEPTH`, 4: number of entries; power of 2, ≥2.
- `LOG_IQ_DEPTH`, 2: log2(`IQ_DEPTH`).

Ports:
- `CLK` in 1: clock; all state updates on posedge.
- `nRST` in 1: reset; one clock, synchronous, active-low.
- `DUT_error` out 1: registered internal-error flag; see Configuration.
- `from_fetch_ivalid` in 1: fetch presents a valid instruction this cycle.
- `from_fetch_instr` in 32: instruction word (`word_t`).
- `from_fetch_PC` in 14: word-granular PC (`pc_t`).
- `from_fetch_nPC` in 14: fetch-predicted next PC (`pc_t`).
- `to_fetch_stall` out 1: queue full; drives fetch stall input.
- `from_pipeline_take_resolved` in 1: redirect; flush queue.
- `from_dispatch_ready` in 1: dispatch consumes head this cycle if valid.
- `to_dispatch_valid` out 1: head entry valid.
- `to_dispatch_instr` out 32: head instruction.
- `to_dispatch_PC` out 14: head PC.
- `to_dispatch_nPC` out 14: head predicted nPC.

## Operation

- Storage: circular array of `IQ_DEPTH` entries {instr, PC, nPC}. `LOG_IQ_DEPTH`-bit head and tail pointers. `(LOG_IQ_DEPTH+1)`-bit count.
- Enqueue: `enq = from_fetch_ivalid & (count != IQ_DEPTH) & ~from_pipeline_take_resolved`. Write at tail, tail+1 (wraps mod `IQ_DEPTH`).
- Dequeue: `deq = from_dispatch_ready & (count != 0) & ~from_pipeline_take_resolved`. Head+1 (wraps).
- Count: +1 on enq only, −1 on deq only, unchanged on both or neither.
- Full: enqueue is refused. There is no bypass: a dequeue in the same cycle does not free space for that cycle's enqueue.
- Empty: dequeue is refused. There is no fall-through: an entry enqueued this cycle is not visible at the outputs until the next cycle.
- Flush: `from_pipeline_take_resolved=1` sets head, tail and count to 0 at the next edge. It overrides any enq/deq in the same cycle. Array contents are don't-care.
- Outputs: `to_dispatch_valid = (count != 0)`. `to_dispatch_instr/PC/nPC` come from the array at head, and are don't-care when not valid.
- `to_fetch_stall = (count == IQ_DEPTH)`. It is a function of registered state only, which leaves no combinational path from fetch inputs.

## Timing

- Reset (nRST=0 at posedge): head=tail=count=0, `DUT_error`=0.
- Reset output values: `to_dispatch_valid`=0, `to_fetch_stall`=0, data outputs don't-care (array not reset).
- Reset mid-operation behaves as a flush. Inputs in the reset cycle are ignored.
- Enqueue-to-dispatch latency: 1 cycle. An instruction enqueued at edge N is presented as `to_dispatch_valid` after edge N, when it is head.
- Stall latency: `to_fetch_stall` rises the cycle after the enqueue that fills the queue. It falls the cycle after the first dequeue from full.
- Flush: the queue is empty the cycle after the redirect. Fetch already masks ivalid during the redirect cycle.
- Throughput: 1 enq + 1 deq per cycle when 0 < count < `IQ_DEPTH`.

## Configuration

- `INSTR_QUEUE_CHECK_EN` defined:
  - `next_DUT_error` is set when `from_fetch_ivalid & to_fetch_stall & ~from_pipeline_take_resolved`, meaning fetch presented a valid instruction while stalled.
  - It is also set when count > `IQ_DEPTH`.
  - `DUT_error` registers this flag one cycle later and is sticky until reset.
  - Each event is also reported via `$display`.
- `INSTR_QUEUE_CHECK_EN` not defined:
  - `DUT_error` is tied to 0 and no check logic is built.
  - Queue behaviour is otherwise identical.

## Test plan

- Reset, then 3 ivalid cycles with PC=0x10,0x11,0x12 and `from_dispatch_ready`=0 → count=3, `to_dispatch_valid`=1 with PC=0x10, `to_fetch_stall`=0.
- Fill to 4 with ivalid held and dispatch stalled → `to_fetch_stall`=1 after the 4th enqueue. A 5th ivalid (PC=0x14) is dropped. With `INSTR_QUEUE_CHECK_EN`, `DUT_error`=1 next cycle.
- Full, then `from_dispatch_ready`=1 and ivalid=1 in the same cycle → head advances, new entry refused, count=3, stall falls next cycle.
- Streaming 10 instructions with ready=1 and ivalid=1 every cycle → in-order output (PC 0x20..0x29), pointers wrap, count stays 1, valid continuous after the first cycle.
- Queue holding 3 entries, `from_pipeline_take_resolved`=1 with ivalid=1 and ready=1 → next cycle valid=0, count=0, stall=0, and nothing from that cycle is dequeued or enqueued.
- Queue holding 2 entries, assert nRST=0 for one edge → valid=0, stall=0, `DUT_error`=0 after the edge.

Source files
------------

// File: rtl/instr_queue.sv
// Instruction queue between fetch and dispatch: circular buffer of {instr, PC, nPC}, flushed on redirect.
// Optional protocol/overflow checking is built when INSTR_QUEUE_CHECK_EN is defined.
module instr_queue #(
  parameter int IQ_DEPTH     = 4,
  parameter int LOG_IQ_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  output logic        DUT_error,
  input  logic        from_fetch_ivalid,
  input  logic [31:0] from_fetch_instr,
  input  logic [13:0] from_fetch_PC,
  input  logic [13:0] from_fetch_nPC,
  output logic        to_fetch_stall,
  input  logic        from_pipeline_take_resolved,
  input  logic        from_dispatch_ready,
  output logic        to_dispatch_valid,
  output logic [31:0] to_dispatch_instr,
  output logic [13:0] to_dispatch_PC,
  output logic [13:0] to_dispatch_nPC
);

  localparam logic [LOG_IQ_DEPTH:0] FULL_COUNT = (LOG_IQ_DEPTH+1)'(IQ_DEPTH);

  logic [31:0] instr_mem [IQ_DEPTH];
  logic [13:0] pc_mem    [IQ_DEPTH];
  logic [13:0] npc_mem   [IQ_DEPTH];

  logic [LOG_IQ_DEPTH-1:0] head;
  logic [LOG_IQ_DEPTH-1:0] tail;
  logic [LOG_IQ_DEPTH:0]   count;
  logic                    enq;
  logic                    deq;

  // Full and empty are judged on registered count only, so a same-cycle dequeue never makes room.
  assign enq = from_fetch_ivalid & (count != FULL_COUNT) & ~from_pipeline_take_resolved;
  assign deq = from_dispatch_ready & (count != '0) & ~from_pipeline_take_resolved;

  assign to_dispatch_valid = (count != '0);
  assign to_fetch_stall    = (count == FULL_COUNT);
  assign to_dispatch_instr = instr_mem[head];
  assign to_dispatch_PC    = pc_mem[head];
  assign to_dispatch_nPC   = npc_mem[head];

  always_ff @(posedge CLK) begin
    if (!nRST || from_pipeline_take_resolved) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= tail + LOG_IQ_DEPTH'(1);
      if (deq) head <= head + LOG_IQ_DEPTH'(1);
      if (enq && !deq)      count <= count + (LOG_IQ_DEPTH+1)'(1);
      else if (deq && !enq) count <= count - (LOG_IQ_DEPTH+1)'(1);
    end
  end

  // Storage is deliberately not reset; contents are only observed when count says they are live.
  always_ff @(posedge CLK) begin
    if (nRST && enq) begin
      instr_mem[tail] <= from_fetch_instr;
      pc_mem[tail]    <= from_fetch_PC;
      npc_mem[tail]   <= from_fetch_nPC;
    end
  end

`ifdef INSTR_QUEUE_CHECK_EN
  logic stall_violation;
  logic count_overflow;
  logic next_dut_error;

  assign stall_violation = from_fetch_ivalid & to_fetch_stall & ~from_pipeline_take_resolved;
  assign count_overflow  = (count > FULL_COUNT);
  assign next_dut_error  = stall_violation | count_overflow;

  // Sticky until reset so a single transient violation is not lost.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      DUT_error <= 1'b0;
    end else begin
      if (next_dut_error) DUT_error <= 1'b1;
      if (stall_violation) $display("instr_queue: fetch presented ivalid while stalled, PC=%h", from_fetch_PC);
      if (count_overflow)  $display("instr_queue: count %0d exceeds depth %0d", count, IQ_DEPTH);
    end
  end
`else
  assign DUT_error = 1'b0;
`endif

endmodule
